// File: rtl/gpio_edge_irq_pkg.sv
// ============================================================================
// Module      : gpio_edge_irq_pkg
// Description : Shared constants for the GPIO edge-interrupt block: register
//               indices (decoded from wb_adr_i[4:2]), synchronizer depth,
//               debounce history length and a byte-lane mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_edge_irq_pkg;

    // Word index within the register window (wb_adr_i[4:2])
    localparam logic [2:0] REG_LEVEL = 3'd0;
    localparam logic [2:0] REG_IE    = 3'd1;
    localparam logic [2:0] REG_RISE  = 3'd2;
    localparam logic [2:0] REG_FALL  = 3'd3;
    localparam logic [2:0] REG_PEND  = 3'd4;
    localparam logic [2:0] REG_DBDIV = 3'd5;

    // Flops between the asynchronous pin and the first usable level
    localparam int SYNC_DEPTH  = 2;

    // Consecutive agreeing samples needed before the debounced level moves
    localparam int DB_HIST_LEN = 3;

    // Expand the four byte-lane selects into a 32-bit write mask
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_edge_irq_filter.sv
// ============================================================================
// Module      : gpio_edge_irq_filter
// Description : Single-pin input conditioner. Two-flop synchronizer followed,
//               when GPIO_EDGE_IRQ_DEBOUNCE_EN is defined, by a 3-sample
//               debounce history advanced on the shared prescaler tick.
// Ports       : clk_i  - system clock
//               rst_i  - asynchronous active-low reset
//               tick_i - debounce sample strike (unused without debounce)
//               pin_i  - raw asynchronous pin level
//               lvl_o  - conditioned level
// Config      : GPIO_EDGE_IRQ_DEBOUNCE_EN enables the debounce history.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_edge_irq_filter
    import gpio_edge_irq_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic pin_i,
    output logic lvl_o
);

    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], pin_i};
        end
    end

`ifdef GPIO_EDGE_IRQ_DEBOUNCE_EN
    logic [DB_HIST_LEN-1:0] hist_q;
    logic [DB_HIST_LEN-1:0] hist_d;
    logic                   lvl_q;
    logic                   lvl_d;

    always_comb begin
        hist_d = hist_q;
        lvl_d  = lvl_q;
        if (tick_i) begin
            hist_d = {hist_q[DB_HIST_LEN-2:0], sync_q[SYNC_DEPTH-1]};
        end
        // Move only once the whole history agrees on the opposite level
        if (lvl_q && (~|hist_q)) begin
            lvl_d = 1'b0;
        end else if (!lvl_q && (&hist_q)) begin
            lvl_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hist_q <= '0;
            lvl_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            lvl_q  <= lvl_d;
        end
    end

    assign lvl_o = lvl_q;
`else
    logic w_unused_tick;
    assign w_unused_tick = tick_i;
    assign lvl_o         = sync_q[SYNC_DEPTH-1];
`endif

endmodule

`default_nettype wire

// File: rtl/gpio_edge_irq.sv
// ============================================================================
// Module      : gpio_edge_irq
// Description : Per-pin edge detector with pending latch and level interrupt,
//               behind a Wishbone slave. Registers: LEVEL, IE, RISE, FALL,
//               PEND (W1C), DBDIV.
// Ports       : clk_i, rst_i (async active-low)
//               wb_cyc_i/wb_stb_i/wb_adr_i/wb_we_i/wb_sel_i/wb_dat_i - bus in
//               wb_dat_o/wb_ack_o                                 - bus out
//               pin_i [PORT_NUM] - raw pins;  irq_o - registered interrupt
// Config      : GPIO_EDGE_IRQ_DEBOUNCE_EN adds the shared debounce prescaler
//               and the DBDIV register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_edge_irq
    import gpio_edge_irq_pkg::*;
#(
    parameter int PORT_NUM = 32,
    parameter int DB_DIV_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic [31:0]         wb_adr_i,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o,
    input  logic [PORT_NUM-1:0] pin_i,
    output logic                irq_o
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic                w_cs;
    logic                w_wr;
    logic [2:0]          w_idx;
    logic [31:0]         w_bmask;
    logic [PORT_NUM-1:0] w_pmask;
    logic [PORT_NUM-1:0] w_pdat;
    logic                w_unused_bus;

    logic                ack_q;
    logic                ack_d;

    assign w_cs    = wb_cyc_i & wb_stb_i;
    // Commit on the edge that raises ack, so a held strobe writes once per ack
    assign w_wr    = w_cs & ~ack_q & wb_we_i;
    assign w_idx   = wb_adr_i[4:2];
    assign w_bmask = byte_mask(wb_sel_i);
    assign w_pmask = w_bmask[PORT_NUM-1:0];
    assign w_pdat  = wb_dat_i[PORT_NUM-1:0] & w_pmask;

    assign w_unused_bus = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

    // ------------------------------------------------------------------
    // Debounce prescaler
    // ------------------------------------------------------------------
    logic        w_tick;
    logic [31:0] w_rd_dbdiv;

`ifdef GPIO_EDGE_IRQ_DEBOUNCE_EN
    logic [DB_DIV_W-1:0] dbdiv_q;
    logic [DB_DIV_W-1:0] dbdiv_d;
    logic [DB_DIV_W-1:0] div_cnt_q;
    logic [DB_DIV_W-1:0] div_cnt_d;
    logic [DB_DIV_W-1:0] w_dmask;

    assign w_dmask    = w_bmask[DB_DIV_W-1:0];
    assign w_tick     = (div_cnt_q == dbdiv_q);
    assign w_rd_dbdiv = 32'(dbdiv_q);

    always_comb begin
        dbdiv_d   = dbdiv_q;
        div_cnt_d = div_cnt_q + {{(DB_DIV_W-1){1'b0}}, 1'b1};
        if (w_tick) begin
            div_cnt_d = '0;
        end
        // A new divider restarts the count so the first tick lands predictably
        if (w_wr && (w_idx == REG_DBDIV)) begin
            dbdiv_d   = (dbdiv_q & ~w_dmask) | (wb_dat_i[DB_DIV_W-1:0] & w_dmask);
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dbdiv_q   <= '0;
            div_cnt_q <= '0;
        end else begin
            dbdiv_q   <= dbdiv_d;
            div_cnt_q <= div_cnt_d;
        end
    end
`else
    logic [DB_DIV_W-1:0] w_unused_div;
    assign w_unused_div = '0;
    assign w_tick       = 1'b0;
    assign w_rd_dbdiv   = '0;
`endif

    // ------------------------------------------------------------------
    // Per-pin conditioning
    // ------------------------------------------------------------------
    logic [PORT_NUM-1:0] w_lvl;

    generate
        for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_pin
            gpio_edge_irq_filter u_filter (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .tick_i (w_tick),
                .pin_i  (pin_i[gi]),
                .lvl_o  (w_lvl[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control registers, edge detection, pending latch, interrupt
    // ------------------------------------------------------------------
    logic [PORT_NUM-1:0] ie_q,      ie_d;
    logic [PORT_NUM-1:0] rise_q,    rise_d;
    logic [PORT_NUM-1:0] fall_q,    fall_d;
    logic [PORT_NUM-1:0] pend_q,    pend_d;
    logic [PORT_NUM-1:0] lvl_dly_q;
    logic                irq_q,     irq_d;
    logic [PORT_NUM-1:0] w_rise_ev;
    logic [PORT_NUM-1:0] w_fall_ev;

    assign w_rise_ev =  w_lvl & ~lvl_dly_q & rise_q;
    assign w_fall_ev = ~w_lvl &  lvl_dly_q & fall_q;

    always_comb begin
        ie_d   = ie_q;
        rise_d = rise_q;
        fall_d = fall_q;
        pend_d = pend_q;
        if (w_wr && (w_idx == REG_IE)) begin
            ie_d = (ie_q & ~w_pmask) | w_pdat;
        end
        if (w_wr && (w_idx == REG_RISE)) begin
            rise_d = (rise_q & ~w_pmask) | w_pdat;
        end
        if (w_wr && (w_idx == REG_FALL)) begin
            fall_d = (fall_q & ~w_pmask) | w_pdat;
        end
        if (w_wr && (w_idx == REG_PEND)) begin
            pend_d = pend_q & ~w_pdat;
        end
        // New edges are OR-ed in after the clear so they win a same-cycle W1C
        pend_d = pend_d | w_rise_ev | w_fall_ev;
        irq_d  = |(pend_q & ie_q);
        ack_d  = w_cs & ~ack_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ie_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            pend_q    <= '0;
            lvl_dly_q <= '0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ie_q      <= ie_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pend_q    <= pend_d;
            lvl_dly_q <= w_lvl;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational, valid while ack is high)
    // ------------------------------------------------------------------
    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            REG_LEVEL: w_rdata = 32'(w_lvl);
            REG_IE:    w_rdata = 32'(ie_q);
            REG_RISE:  w_rdata = 32'(rise_q);
            REG_FALL:  w_rdata = 32'(fall_q);
            REG_PEND:  w_rdata = 32'(pend_q);
            REG_DBDIV: w_rdata = w_rd_dbdiv;
            default:   w_rdata = '0;
        endcase
    end

    assign wb_dat_o = w_rdata;
    assign wb_ack_o = ack_q;
    assign irq_o    = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_edge_irq.sv
// ============================================================================
// Module      : tb_gpio_edge_irq
// Description : Self-checking bench for gpio_edge_irq. A behavioural model
//               (pin samples delayed two cycles, register image, pending set)
//               is stepped alongside the DUT every clock; directed scenarios
//               are followed by a randomized register/pin phase.
// Config      : GPIO_EDGE_IRQ_DEBOUNCE_EN selects the debounce scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_edge_irq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [31:0] pin;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        irq_o;

    always #5 clk = ~clk;

    gpio_edge_irq #(.PORT_NUM(32), .DB_DIV_W(16)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_adr_i (adr),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_dat_i (dat),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .pin_i    (pin),
        .irq_o    (irq_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_ie, m_rise, m_fall, m_pend, m_dbdiv;
    logic [31:0] m_s0, m_s1, m_s2;  // pin sampled 1, 2, 3 edges ago
    logic        m_irq, m_ack;
    bit          chk_level = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_dbdiv = '0;
        m_s0 = '0; m_s1 = '0; m_s2 = '0;
        m_irq = 1'b0; m_ack = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] idx);
        case (idx)
            3'd0: return m_s1;
            3'd1: return m_ie;
            3'd2: return m_rise;
            3'd3: return m_fall;
            3'd4: return m_pend;
`ifdef GPIO_EDGE_IRQ_DEBOUNCE_EN
            3'd5: return m_dbdiv;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One clock: derive next model state from the pre-edge inputs, clock,
    // then compare the DUT outputs against the model.
    task automatic step();
        logic        cs, commit, wr;
        logic [2:0]  idx;
        logic [31:0] mask, wv, rise_ev, fall_ev, n_pend, smp;
        logic        n_irq;
        cs     = cyc & stb;
        commit = cs & ~m_ack;
        wr     = commit & we;
        idx    = adr[4:2];
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{sel[b]}};
        wv      = dat & mask;
        rise_ev =  m_s1 & ~m_s2 & m_rise;
        fall_ev = ~m_s1 &  m_s2 & m_fall;
        n_pend  = m_pend;
        if (wr && idx == 3'd4) n_pend = n_pend & ~wv;
        n_pend  = n_pend | rise_ev | fall_ev;
        n_irq   = |(m_pend & m_ie);
        smp     = pin;
        @(posedge clk);
        if (wr) begin
            case (idx)
                3'd1: m_ie    = (m_ie   & ~mask) | wv;
                3'd2: m_rise  = (m_rise & ~mask) | wv;
                3'd3: m_fall  = (m_fall & ~mask) | wv;
                3'd5: m_dbdiv = ((m_dbdiv & ~mask) | wv) & 32'h0000_FFFF;
                default: ;
            endcase
        end
        m_pend = n_pend;
        m_irq  = n_irq;
        m_ack  = commit;
        m_s2   = m_s1;
        m_s1   = m_s0;
        m_s0   = smp;
        #1;
        check("irq", {31'b0, irq_o}, {31'b0, m_irq});
        check("ack", {31'b0, wb_ack_o}, {31'b0, m_ack});
        if (m_ack && !we && (chk_level || idx != 3'd0))
            check($sformatf("rdata[%0d]", idx), wb_dat_o, m_read(idx));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wb_access(input logic [2:0] idx, input logic w, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd);
        int k;
        cyc = 1'b1; stb = 1'b1; we = w; adr = {27'd0, idx, 2'b00}; dat = d; sel = s;
        k = 0;
        do begin
            step();
            k++;
        end while (!wb_ack_o && k < 4);
        check("ack_seen", {31'b0, wb_ack_o}, 32'h1);
        rd  = wb_dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        logic [31:0] rd;
        wb_access(idx, 1'b1, d, 4'hF, rd);
    endtask

    logic [31:0] rd;
    int          lat;
    logic        hold_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat = '0; sel = '0; pin = 32'hFFFF_FFFF;
        model_reset();
`ifdef GPIO_EDGE_IRQ_DEBOUNCE_EN
        chk_level = 1'b0;
`endif
        // ---------------- reset state ----------------
        #12;
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        check("rst_ack", {31'b0, wb_ack_o}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        steps(8);
        wb_access(3'd0, 1'b0, '0, 4'hF, rd);
        check("level_after_reset", rd, 32'hFFFF_FFFF);
        wb_access(3'd4, 1'b0, '0, 4'hF, rd);
        check("pend_after_reset", rd, 32'h0);

        // ---------------- held strobe: ack 0,1,0,1,0 ----------------
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; dat = 32'h0; sel = 4'hF;
        check("hold_ack_start", {31'b0, wb_ack_o}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("hold_ack%0d", i + 1), {31'b0, wb_ack_o}, {31'b0, hold_exp[i]});
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();

`ifndef GPIO_EDGE_IRQ_DEBOUNCE_EN
        // ---------------- rising edge on pin 0, 4-cycle irq latency ----------------
        pin = 32'h0;
        steps(4);
        wr(3'd2, 32'h1);
        wr(3'd1, 32'h1);
        pin[0] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (irq_o && lat == 0) lat = i;
        end
        check("irq_latency", lat, 32'd4);
        wb_access(3'd4, 1'b0, '0, 4'hF, rd);
        check("pend_rise0", rd, 32'h1);

        // ---------------- falling edge pin 31 with IE masked ----------------
        wr(3'd1, 32'h0);
        pin[31] = 1'b1;
        steps(4);
        wr(3'd3, 32'h8000_0000);
        pin[31] = 1'b0;
        steps(5);
        wb_access(3'd4, 1'b0, '0, 4'hF, rd);
        check("pend_fall31", rd, 32'h8000_0001);
        check("irq_masked", {31'b0, irq_o}, 32'h0);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; dat = 32'h8000_0000; sel = 4'hF;
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();
        check("irq_after_ie", {31'b0, irq_o}, 32'h1);

        // ---------------- W1C racing a new edge ----------------
        wr(3'd4, 32'h8000_0000);
        wr(3'd1, 32'h1);
        pin[0] = 1'b0;
        steps(4);
        pin[0] = 1'b1;
        steps(2);
        wb_access(3'd4, 1'b1, 32'h1, 4'h1, rd);
        wb_access(3'd4, 1'b0, '0, 4'hF, rd);
        check("pend_race", rd, 32'h1);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; dat = 32'h1; sel = 4'h1;
        step();
        check("irq_before_fall", {31'b0, irq_o}, 32'h1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();
        check("irq_fell", {31'b0, irq_o}, 32'h0);

        // ---------------- randomized phase ----------------
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 5))
                0: begin pin = $urandom; steps($urandom_range(1, 4)); end
                1: wb_access(3'd1, 1'b1, $urandom, 4'($urandom_range(1, 15)), rd);
                2: wb_access(3'd2, 1'b1, $urandom, 4'($urandom_range(1, 15)), rd);
                3: wb_access(3'd3, 1'b1, $urandom, 4'($urandom_range(1, 15)), rd);
                4: wb_access(3'd4, 1'b1, $urandom, 4'($urandom_range(1, 15)), rd);
                default: wb_access(3'($urandom_range(0, 7)), 1'b0, '0, 4'hF, rd);
            endcase
        end
`else
        // ---------------- debounce: glitch rejected, held level accepted ----------------
        pin = 32'h0;
        steps(10);
        wr(3'd5, 32'h3);
        wb_access(3'd5, 1'b0, '0, 4'hF, rd);
        check("dbdiv_rd", rd, 32'h3);
        pin[2] = 1'b1;
        steps(4);
        pin[2] = 1'b0;
        steps(20);
        wb_access(3'd0, 1'b0, '0, 4'hF, rd);
        check("db_glitch", rd & 32'h4, 32'h0);
        pin[2] = 1'b1;
        steps(20);
        wb_access(3'd0, 1'b0, '0, 4'hF, rd);
        check("db_held", rd & 32'h4, 32'h4);
`endif

        // ---------------- mid-access reset ----------------
        wr(3'd2, 32'hFFFF_FFFF);
        pin = 32'h0;
        steps(4);
        pin = 32'hFFFF_FFFF;
        steps(30);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_ack", {31'b0, wb_ack_o}, 32'h0);
        check("midrst_irq", {31'b0, irq_o}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        steps(8);
        wb_access(3'd4, 1'b0, '0, 4'hF, rd);
        check("pend_after_midrst", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
